// File: rtl/ram_pkg.sv
// ram_pkg: shared constants and state type for the RAM access controller.
//   DATA_W    - RAM word width
//   ADDR_W    - RAM address width (depth = 2^ADDR_W)
//   LEN_W     - burst length field width (beats = len + 1)
//   RAM_DEPTH - number of RAM words
// The controller state enum gains a CLEAR state when RAM_CLEAR_EN is defined.
package ram_pkg;

  localparam int DATA_W    = 32;
  localparam int ADDR_W    = 5;
  localparam int LEN_W     = 3;
  localparam int RAM_DEPTH = 1 << ADDR_W;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR_BEAT = 3'd1,
    ST_RD_ADDR = 3'd2,
    ST_RD_DATA = 3'd3
`ifdef RAM_CLEAR_EN
    , ST_CLEAR = 3'd4
`endif
  } ram_ctrl_state_t;

endpackage

// File: rtl/ram_addr_gen.sv
// ram_addr_gen: burst address register and remaining-beat counter.
//   clk, rst   - clock and synchronous active-high reset (clears both to 0)
//   load       - capture load_addr / load_len at the start of a burst
//   load_addr  - first word address of the burst
//   load_len   - beats minus one
//   step       - advance to the next beat (addr+1 modulo depth, count-1)
//   addr       - current word address
//   last       - current beat is the final one of the burst (count == 0)
module ram_addr_gen
  import ram_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [LEN_W-1:0]  load_len,
  input  logic              step,
  output logic [ADDR_W-1:0] addr,
  output logic              last
);

  logic [LEN_W-1:0] count;

  // Address wraps naturally at 2^ADDR_W because the register is exactly
  // ADDR_W bits wide; the counter may wrap too but is reloaded per burst.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr  <= '0;
      count <= '0;
    end else if (load) begin
      addr  <= load_addr;
      count <= load_len;
    end else if (step) begin
      addr  <= addr + ADDR_W'(1);
      count <= count - LEN_W'(1);
    end
  end

  assign last = (count == '0);

endmodule

// File: rtl/ram_access_ctrl.sv
// ram_access_ctrl: burst sequencer that owns the single-port RAM interface.
// Accepts read/write bursts of 1..8 words on a valid/ready request channel,
// streams write beats in on wdata_*, streams read beats out on rdata_*, and
// drives the RAM ena/wena/addr/data_in from registers only.
//   clk, rst                         - clock, synchronous active-high reset
//   req_valid/req_ready/req_write/req_addr/req_len - burst request channel
//   wdata_valid/wdata_ready/wdata    - write beat channel
//   rdata_valid/rdata_ready/rdata/rdata_last - read beat channel
//   done                             - one-cycle pulse after a burst completes
//   ram_ena/ram_wena/ram_addr/ram_din - to the RAM
//   ram_dout                         - from the RAM (ignored unless reading)
// Optional feature macro: RAM_CLEAR_EN -- after reset, zero every RAM word
// (one per cycle) before accepting requests.
module ram_access_ctrl
  import ram_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [LEN_W-1:0]  req_len,
  input  logic              wdata_valid,
  output logic              wdata_ready,
  input  logic [DATA_W-1:0] wdata,
  output logic              rdata_valid,
  input  logic              rdata_ready,
  output logic [DATA_W-1:0] rdata,
  output logic              rdata_last,
  output logic              done,
  output logic              ram_ena,
  output logic              ram_wena,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout
);

`ifdef RAM_CLEAR_EN
  localparam ram_ctrl_state_t RESET_STATE = ST_CLEAR;
`else
  localparam ram_ctrl_state_t RESET_STATE = ST_IDLE;
`endif

  ram_ctrl_state_t state, next_state;

  logic              req_hs, wr_hs, rd_hs;
  logic              clear_step;
  logic              ag_step, ag_last;
  logic [ADDR_W-1:0] cur_addr;

  logic              req_ready_nxt, wdata_ready_nxt, done_nxt;
  logic              rdata_valid_nxt, rdata_last_nxt;
  logic [DATA_W-1:0] rdata_nxt;
  logic              ram_ena_nxt, ram_wena_nxt;
  logic [ADDR_W-1:0] ram_addr_nxt;
  logic [DATA_W-1:0] ram_din_nxt;

  // Handshakes are qualified by state as well as by the registered ready
  // flags so a stale flag can never be mistaken for a transfer.
  assign req_hs = (state == ST_IDLE)    && req_valid   && req_ready;
  assign wr_hs  = (state == ST_WR_BEAT) && wdata_valid && wdata_ready;
  assign rd_hs  = (state == ST_RD_DATA) && rdata_valid && rdata_ready;

`ifdef RAM_CLEAR_EN
  assign clear_step = (state == ST_CLEAR);
`else
  assign clear_step = 1'b0;
`endif

  // The address generator doubles as the clear-address counter; reset
  // zeroes it, which is exactly where a clear sweep must start.
  assign ag_step = wr_hs || (rd_hs && !ag_last) || clear_step;

  ram_addr_gen u_addr_gen (
    .clk       (clk),
    .rst       (rst),
    .load      (req_hs),
    .load_addr (req_addr),
    .load_len  (req_len),
    .step      (ag_step),
    .addr      (cur_addr),
    .last      (ag_last)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= RESET_STATE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:    if (req_hs) next_state = req_write ? ST_WR_BEAT : ST_RD_ADDR;
      ST_WR_BEAT: if (wr_hs && ag_last) next_state = ST_IDLE;
      ST_RD_ADDR: next_state = ST_RD_DATA;
      ST_RD_DATA: if (rd_hs) next_state = ag_last ? ST_IDLE : ST_RD_ADDR;
`ifdef RAM_CLEAR_EN
      ST_CLEAR:   if (cur_addr == ADDR_W'(RAM_DEPTH - 1)) next_state = ST_IDLE;
`endif
      default:    next_state = ST_IDLE;
    endcase
  end

  // Next values for every output register. The ready flags follow the
  // next state so they are already correct in the first cycle of a state.
  // In RD_DATA, rdata_valid low means the RAM word has not been captured
  // yet; the first cycle captures it and later cycles wait for the consumer.
  always_comb begin
    req_ready_nxt   = (next_state == ST_IDLE);
    wdata_ready_nxt = (next_state == ST_WR_BEAT);
    done_nxt        = (wr_hs || rd_hs) && ag_last;
    rdata_nxt       = rdata;
    rdata_valid_nxt = rdata_valid;
    rdata_last_nxt  = rdata_last;
    ram_ena_nxt     = 1'b0;
    ram_wena_nxt    = 1'b0;
    ram_addr_nxt    = ram_addr;
    ram_din_nxt     = ram_din;
    case (state)
      ST_WR_BEAT: begin
        if (wr_hs) begin
          ram_ena_nxt  = 1'b1;
          ram_wena_nxt = 1'b1;
          ram_addr_nxt = cur_addr;
          ram_din_nxt  = wdata;
        end
      end
      ST_RD_ADDR: begin
        ram_ena_nxt  = 1'b1;
        ram_addr_nxt = cur_addr;
      end
      ST_RD_DATA: begin
        ram_ena_nxt = 1'b1;
        if (!rdata_valid) begin
          rdata_nxt       = ram_dout;
          rdata_valid_nxt = 1'b1;
          rdata_last_nxt  = ag_last;
        end else if (rdata_ready) begin
          rdata_valid_nxt = 1'b0;
          rdata_last_nxt  = 1'b0;
          ram_ena_nxt     = 1'b0;
        end
      end
`ifdef RAM_CLEAR_EN
      ST_CLEAR: begin
        ram_ena_nxt  = 1'b1;
        ram_wena_nxt = 1'b1;
        ram_addr_nxt = cur_addr;
        ram_din_nxt  = '0;
      end
`endif
      default: begin
      end
    endcase
  end

  // Reset forces ram_ena low at the reset edge, so an aborted burst never
  // issues a fresh RAM write.
  always_ff @(posedge clk) begin
    if (rst) begin
      req_ready   <= 1'b0;
      wdata_ready <= 1'b0;
      done        <= 1'b0;
      rdata       <= '0;
      rdata_valid <= 1'b0;
      rdata_last  <= 1'b0;
      ram_ena     <= 1'b0;
      ram_wena    <= 1'b0;
      ram_addr    <= '0;
      ram_din     <= '0;
    end else begin
      req_ready   <= req_ready_nxt;
      wdata_ready <= wdata_ready_nxt;
      done        <= done_nxt;
      rdata       <= rdata_nxt;
      rdata_valid <= rdata_valid_nxt;
      rdata_last  <= rdata_last_nxt;
      ram_ena     <= ram_ena_nxt;
      ram_wena    <= ram_wena_nxt;
      ram_addr    <= ram_addr_nxt;
      ram_din     <= ram_din_nxt;
    end
  end

endmodule

// File: tb/tb_ram_access_ctrl.sv
// tb_ram_access_ctrl: bench for ram_access_ctrl with a behavioural 32x32 RAM
// and a word-array reference of what the RAM should hold.
// Honours RAM_CLEAR_EN when the design is built with it.
module tb_ram_access_ctrl;

  logic        clk;
  logic        rst;
  logic        req_valid, req_ready, req_write;
  logic [4:0]  req_addr;
  logic [2:0]  req_len;
  logic        wdata_valid, wdata_ready;
  logic [31:0] wdata;
  logic        rdata_valid, rdata_ready, rdata_last;
  logic [31:0] rdata;
  logic        done;
  logic        ram_ena, ram_wena;
  logic [4:0]  ram_addr;
  logic [31:0] ram_din, ram_dout;

  logic [31:0] mem [0:31];
  logic [31:0] ref_mem [0:31];
  logic [31:0] wbuf [0:7];

  int checks = 0;
  int failures = 0;
  int wr_commits = 0;
  int done_count = 0;
  int wena_bad = 0;

  ram_access_ctrl dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_len(req_len),
    .wdata_valid(wdata_valid), .wdata_ready(wdata_ready), .wdata(wdata),
    .rdata_valid(rdata_valid), .rdata_ready(rdata_ready), .rdata(rdata),
    .rdata_last(rdata_last), .done(done),
    .ram_ena(ram_ena), .ram_wena(ram_wena), .ram_addr(ram_addr),
    .ram_din(ram_din), .ram_dout(ram_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural RAM: asynchronous read, tri-stated when not reading.
  assign ram_dout = (ram_ena && !ram_wena) ? mem[ram_addr] : 32'hzzzz_zzzz;
  always @(posedge clk) if (ram_ena && ram_wena) mem[ram_addr] <= ram_din;

  // Bus monitor sampled mid-cycle: write commits, done pulses, illegal wena.
  always @(negedge clk) begin
    if (ram_ena === 1'b1 && ram_wena === 1'b1) wr_commits++;
    if (ram_wena === 1'b1 && ram_ena !== 1'b1) wena_bad++;
    if (done === 1'b1) done_count++;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic rv, input logic rw, input logic [4:0] a, input logic [2:0] len);
    req_valid = rv;
    req_write = rw;
    req_addr  = a;
    req_len   = len;
  endtask

  task automatic waitReqReady(input string tag);
    int t = 0;
    while (!req_ready && t < 100) begin tick(); t++; end
    if (!req_ready) checkOutput({tag, "_req_timeout"}, 32'(req_ready), 32'd1);
  endtask

  task automatic doReset();
    int cnt = 0;
    rst = 1'b1;
    req_valid = 1'b0; wdata_valid = 1'b0; rdata_ready = 1'b0;
    tick(); tick();
    checkOutput("rst_req_ready",   32'(req_ready),   32'd0);
    checkOutput("rst_wdata_ready", 32'(wdata_ready), 32'd0);
    checkOutput("rst_rdata_valid", 32'(rdata_valid), 32'd0);
    checkOutput("rst_rdata_last",  32'(rdata_last),  32'd0);
    checkOutput("rst_done",        32'(done),        32'd0);
    checkOutput("rst_ram_ena",     32'(ram_ena),     32'd0);
    checkOutput("rst_ram_wena",    32'(ram_wena),    32'd0);
    checkOutput("rst_ram_addr",    32'(ram_addr),    32'd0);
    checkOutput("rst_ram_din",     ram_din,          32'd0);
    checkOutput("rst_rdata",       rdata,            32'd0);
    rst = 1'b0;
    while (!req_ready && cnt < 200) begin tick(); cnt++; end
`ifdef RAM_CLEAR_EN
    checkOutput("clear_ready_low_cycles", 32'(cnt), 32'd32);
    for (int i = 0; i < 32; i++) ref_mem[i] = 32'd0;
`else
    checkOutput("rst_ready_low_cycles", 32'(cnt), 32'd1);
`endif
  endtask

  // Write burst from wbuf; optional random wdata gaps; optional competing
  // request held high for the whole burst (must not be accepted).
  task automatic writeBurst(input logic [4:0] a, input logic [2:0] len,
                            input bit gaps, input bit holdReq, input string tag);
    int t;
    int busyReady = 0;
    int commits0;
    logic [4:0] ba;
    waitReqReady(tag);
    applyStimulus(1'b1, 1'b1, a, len);
    tick();
    if (holdReq) applyStimulus(1'b1, 1'b0, ~a, 3'd7);
    else         req_valid = 1'b0;
    commits0 = wr_commits;
    for (int b = 0; b <= int'(len); b++) begin
      ba = a + 5'(b);
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          tick();
          if (req_ready) busyReady++;
        end
      end
      wdata_valid = 1'b1;
      wdata = wbuf[b];
      t = 0;
      while (!wdata_ready && t < 50) begin tick(); t++; end
      if (!wdata_ready) checkOutput({tag, "_wready_timeout"}, 32'(wdata_ready), 32'd1);
      tick();
      wdata_valid = 1'b0;
      if (holdReq && b == int'(len)) req_valid = 1'b0;
      ref_mem[ba] = wbuf[b];
      checkOutput({tag, "_ram_ena"},  32'(ram_ena),  32'd1);
      checkOutput({tag, "_ram_wena"}, 32'(ram_wena), 32'd1);
      checkOutput({tag, "_ram_addr"}, 32'(ram_addr), 32'(ba));
      checkOutput({tag, "_ram_din"},  ram_din,       wbuf[b]);
      if (b != int'(len) && req_ready) busyReady++;
    end
    checkOutput({tag, "_done"},      32'(done),      32'd1);
    checkOutput({tag, "_req_ready"}, 32'(req_ready), 32'd1);
    tick();
    checkOutput({tag, "_done_pulse"}, 32'(done), 32'd0);
    checkOutput({tag, "_commits"}, 32'(wr_commits - commits0), 32'(int'(len) + 1));
    if (holdReq) checkOutput({tag, "_busy_ready"}, 32'(busyReady), 32'd0);
  endtask

  // Read burst checked against ref_mem; optional fixed stall on one beat or
  // random consumer delay.
  task automatic readBurst(input logic [4:0] a, input logic [2:0] len, input int stallBeat,
                           input int stallCycles, input bit randReady, input string tag);
    int t;
    logic [4:0] ba;
    logic [31:0] expd;
    waitReqReady(tag);
    applyStimulus(1'b1, 1'b0, a, len);
    tick();
    req_valid = 1'b0;
    for (int b = 0; b <= int'(len); b++) begin
      ba = a + 5'(b);
      expd = ref_mem[ba];
      t = 0;
      while (!rdata_valid && t < 50) begin tick(); t++; end
      checkOutput({tag, "_valid"}, 32'(rdata_valid), 32'd1);
      if (b == 0) checkOutput({tag, "_first_latency"}, 32'(t), 32'd2);
      if (b == stallBeat) begin
        for (int s = 0; s < stallCycles; s++) begin
          checkOutput({tag, "_stall_rdata"}, rdata, expd);
          checkOutput({tag, "_stall_addr"}, 32'(ram_addr), 32'(ba));
          tick();
        end
      end else if (randReady) begin
        repeat ($urandom_range(0, 2)) tick();
      end
      checkOutput({tag, "_data"}, rdata, expd);
      checkOutput({tag, "_last"}, 32'(rdata_last), 32'(b == int'(len)));
      rdata_ready = 1'b1;
      tick();
      rdata_ready = 1'b0;
    end
    checkOutput({tag, "_done"}, 32'(done), 32'd1);
    tick();
    checkOutput({tag, "_done_pulse"}, 32'(done), 32'd0);
  endtask

  task automatic idleCheck(input int n, input string tag);
    int bad = 0;
    repeat (n) begin
      tick();
      if (ram_ena !== 1'b0 || ram_wena !== 1'b0) bad++;
    end
    checkOutput(tag, 32'(bad), 32'd0);
  endtask

  initial begin
    int doneBefore;
    logic [4:0] ra;
    logic [2:0] rl;
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 5'd0, 3'd0);
    wdata_valid = 1'b0; wdata = 32'd0; rdata_ready = 1'b0;
    doReset();

    // Single-word write then read back.
    wbuf[0] = 32'hDEADBEEF;
    writeBurst(5'd5, 3'd0, 1'b0, 1'b0, "single_wr");
    readBurst(5'd5, 3'd0, -1, 0, 1'b0, "single_rd");
    idleCheck(4, "idle_after_single");

    // Eight-beat burst wrapping from 31 to 0.
    for (int i = 0; i < 8; i++) wbuf[i] = 32'(i);
    writeBurst(5'd30, 3'd7, 1'b0, 1'b0, "wrap_wr");
    checkOutput("wrap_mem30", mem[30], 32'd0);
    checkOutput("wrap_mem31", mem[31], 32'd1);
    checkOutput("wrap_mem0",  mem[0],  32'd2);
    checkOutput("wrap_mem5",  mem[5],  32'd7);
    readBurst(5'd30, 3'd7, -1, 0, 1'b0, "wrap_rd");

    // Write with wdata gaps, read with a 4-cycle stall on beat 2.
    for (int i = 0; i < 8; i++) wbuf[i] = $urandom;
    writeBurst(5'd9, 3'd3, 1'b1, 1'b0, "gap_wr");
    readBurst(5'd9, 3'd3, 2, 4, 1'b0, "stall_rd");
    idleCheck(4, "idle_after_stall");

    // Competing request held high while busy.
    for (int i = 0; i < 8; i++) wbuf[i] = $urandom;
    writeBurst(5'd20, 3'd3, 1'b0, 1'b1, "busy_wr");
    readBurst(5'd20, 3'd3, -1, 0, 1'b1, "busy_rd");

    // Reset after 2 of 4 write beats.
    for (int i = 0; i < 8; i++) wbuf[i] = $urandom;
    writeBurst(5'd12, 3'd3, 1'b0, 1'b0, "pre_abort_wr");
    waitReqReady("abort");
    applyStimulus(1'b1, 1'b1, 5'd12, 3'd3);
    tick();
    req_valid = 1'b0;
    for (int b = 0; b < 2; b++) begin
      wbuf[b] = $urandom;
      wdata_valid = 1'b1;
      wdata = wbuf[b];
      checkOutput("abort_wready", 32'(wdata_ready), 32'd1);
      tick();
      ref_mem[5'd12 + 5'(b)] = wbuf[b];
    end
    wdata_valid = 1'b0;
    doneBefore = done_count;
    rst = 1'b1;
    tick();
    checkOutput("abort_ram_ena", 32'(ram_ena), 32'd0);
    checkOutput("abort_done",    32'(done),    32'd0);
    doReset();
    checkOutput("abort_no_done", 32'(done_count - doneBefore), 32'd0);
    readBurst(5'd12, 3'd3, -1, 0, 1'b0, "abort_rd");

    // Random bursts with random gaps and consumer delays.
    for (int it = 0; it < 6; it++) begin
      ra = 5'($urandom_range(0, 31));
      rl = 3'($urandom_range(0, 7));
      for (int i = 0; i < 8; i++) wbuf[i] = $urandom;
      writeBurst(ra, rl, 1'b1, 1'b0, "rand_wr");
      readBurst(ra, rl, -1, 0, 1'b1, "rand_rd");
    end

`ifdef RAM_CLEAR_EN
    // Preloaded words must read as zero after the post-reset clear.
    wbuf[0] = 32'hA5A5_0001;
    writeBurst(5'd0, 3'd0, 1'b0, 1'b0, "clr_pre0");
    wbuf[0] = 32'hA5A5_001F;
    writeBurst(5'd31, 3'd0, 1'b0, 1'b0, "clr_pre31");
    doReset();
    readBurst(5'd0, 3'd0, -1, 0, 1'b0, "clr_rd0");
    readBurst(5'd31, 3'd0, -1, 0, 1'b0, "clr_rd31");
`endif

    idleCheck(4, "idle_final");
    checkOutput("wena_without_ena", 32'(wena_bad), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
